wide_add_sequencer: RTL and testbench

//   Multi-cycle wide adder front end. Accepts two WORDS*N-bit operands on a valid/ready handshake
//   and drives one N-bit ripple adder one chunk per cycle, LSB chunk first. It registers the carry

---
 rtl/wide_add_pkg.sv | 25 ++
 rtl/wide_add_sequencer_full_adder.sv | 25 ++
 rtl/wide_add_sequencer.sv | 146 ++++++++++++++
 tb/tb_wide_add_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the wide adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wide_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ceiling log2, floored at 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      if (res < 1) begin
         res = 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/wide_add_sequencer_full_adder.sv
// N-bit ripple-carry chunk adder: {c_out,sum} = a + b + c_in.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module full_adder_n_bit #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] sum,
   output logic         c_out
);

   logic [N:0] cy;

   assign cy[0] = c_in;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b[i] ^ cy[i];
      assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
   end

   assign c_out = cy[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// Sequenced W-bit adder: one N-bit chunk per cycle, LSB first (WIDE_ADD_SUB_EN adds op_sub).
// Latency: out_valid rises WORDS cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   in_a,
   input  logic [N*WORDS-1:0]   in_b,
   input  logic                 in_c,
`ifdef WIDE_ADD_SUB_EN
   input  logic                 op_sub,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   out_sum,
   output logic                 out_c
);

   localparam int W  = N * WORDS;
   localparam int IW = clog2(WORDS);
   localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

   state_t        state;
   state_t        state_nxt;
   logic          load;
   logic          step;

   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  res_q;
   logic          carry_q;
   logic [IW-1:0] idx_q;

   logic [N-1:0]  add_a;
   logic [N-1:0]  add_b;
   logic [N-1:0]  add_sum;
   logic          add_c_out;
   logic          init_c;

`ifdef WIDE_ADD_SUB_EN
   logic          sub_q;

   // Subtraction: invert B per chunk and force the initial carry to 1 (two's complement).
   assign add_b  = sub_q ? ~b_sh[N-1:0] : b_sh[N-1:0];
   assign init_c = op_sub ? 1'b1 : in_c;

   // Operation mode is captured with the operands and held for the whole run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= 1'b0;
      end else if (load) begin
         sub_q <= op_sub;
      end
   end
`else
   assign add_b  = b_sh[N-1:0];
   assign init_c = in_c;
`endif

   assign add_a = a_sh[N-1:0];

   full_adder_n_bit #(.N(N)) u_chunk_add (
      .a     (add_a),
      .b     (add_b),
      .c_in  (carry_q),
      .sum   (add_sum),
      .c_out (add_c_out)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake decode; load/step strobe the datapath.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (idx_q == IDX_LAST) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath: load operands on accept, then shift one chunk per RUN cycle.
   // The result register fills from the top so the LSB chunk lands at the bottom
   // after WORDS shifts; it is untouched in DONE, which keeps out_sum stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else if (load) begin
         a_sh    <= in_a;
         b_sh    <= in_b;
         carry_q <= init_c;
         idx_q   <= '0;
      end else if (step) begin
         a_sh    <= a_sh >> N;
         b_sh    <= b_sh >> N;
         res_q   <= {add_sum, res_q[W-1:N]};
         carry_q <= add_c_out;
         idx_q   <= idx_q + 1'b1;
      end
   end

   assign out_sum = res_q;
   assign out_c   = carry_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (N=4, WORDS=4).
// Latency: checks out_valid rises WORDS cycles after accept.
// Backpressure: checks hold in DONE and in_valid ignored outside IDLE.
module tb_wide_add_sequencer;

   localparam int N     = 4;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_c;
   logic         op_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_c;

   int n_tests;
   int n_fail;

   wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
`ifdef WIDE_ADD_SUB_EN
      .op_sub    (op_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_c     (out_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on whole operands.
   function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c, input logic s);
      logic [W:0] r;
      if (s) begin
         r[W-1:0] = a - b;
         r[W]     = (a >= b);
      end else begin
         r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      end
      return r;
   endfunction

   task automatic wait_idle(input string nm);
      int t;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: in_ready timeout, got %b want 1", nm, in_ready);
      end
   endtask

   // One full transaction: accept, latency, result, optional hold, handshake.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input int hold, input string nm);
      logic [W:0] exp;
      int lat;
      exp = ref_result(a, b, c, s);
      wait_idle(nm);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_c     = c;
      op_sub   = s;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_tests++;
      if (lat !== WORDS) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", nm, lat, WORDS);
      end
      n_tests++;
      if ({out_c, out_sum} !== exp) begin
         n_fail++;
         $display("FAIL %s result: got c=%b sum=%h want c=%b sum=%h",
                  nm, out_c, out_sum, exp[W], exp[W-1:0]);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1 || {out_c, out_sum} !== exp) begin
            n_fail++;
            $display("FAIL %s hold: got v=%b c=%b sum=%h want v=1 c=%b sum=%h",
                     nm, out_valid, out_c, out_sum, exp[W], exp[W-1:0]);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", nm, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_c !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got rdy=%b v=%b sum=%h c=%b want rdy=1 v=0 sum=0 c=0",
                  in_ready, out_valid, out_sum, out_c);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_op(16'h1234, 16'h0001, 1'b0, 1'b0, 0, "add_basic");
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_ripple");
      run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0, "add_cin");
   endtask

   task automatic test_backpressure();
      logic [W:0] exp;
      int lat;
      exp = ref_result(16'hABCD, 16'h1111, 1'b1, 1'b0);
      wait_idle("bp");
      in_valid = 1'b1;
      in_a = 16'hABCD; in_b = 16'h1111; in_c = 1'b1; op_sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         in_a = W'($urandom);
         in_b = W'($urandom);
         @(negedge clk);
         n_tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_c, out_sum} !== exp) begin
            n_fail++;
            $display("FAIL bp_hold: got rdy=%b v=%b c=%b sum=%h want rdy=0 v=1 c=%b sum=%h",
                     in_ready, out_valid, out_c, out_sum, exp[W], exp[W-1:0]);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
      run_op(16'h4321, 16'h1234, 1'b0, 1'b0, 0, "bp_next");
   endtask

   task automatic test_reset_mid_run();
      wait_idle("rst_run");
      in_valid = 1'b1;
      in_a = 16'h5555; in_b = 16'h3333; in_c = 1'b0; op_sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || ^{out_c, out_sum} === 1'bx) begin
         n_fail++;
         $display("FAIL rst_run: got v=%b rdy=%b sum=%h want v=0 rdy=1 non-X",
                  out_valid, in_ready, out_sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0, "after_rst");
   endtask

`ifdef WIDE_ADD_SUB_EN
   task automatic test_sub();
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_borrow");
      run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, "sub_noborrow");
   endtask
`endif

   task automatic test_random();
      logic s;
      for (int k = 0; k < 40; k++) begin
         s = 1'b0;
`ifdef WIDE_ADD_SUB_EN
         s = 1'($urandom_range(0, 1));
`endif
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s,
                $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_c      = 1'b0;
      op_sub    = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
`ifdef WIDE_ADD_SUB_EN
      test_sub();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
